cxu_arbiter: RTL

//  Shares one downstream CXU (custom function unit, valid/ready request/response) among N_REQ requesters.

---
 rtl/cxu_arb_pkg.sv | 48 ++++
 rtl/cxu_arb_id_fifo.sv | 86 ++++++++
 rtl/cxu_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cxu_arb_pkg.sv
// ---------------------------------------------------------------------------
// cxu_arb_pkg
//   Shared types and helpers for the CXU arbiter:
//     id_t              requester ID carried through the in-flight ID FIFO
//     rr_pick()         round-robin grant selection
//     check_param_*()   elaboration-time parameter legality checks
// ---------------------------------------------------------------------------
package cxu_arb_pkg;

    // Largest legal requester count; id_t is sized for it so one type serves
    // every instance regardless of its N_REQ.
    localparam int MAX_N_REQ = 16;
    localparam int ID_W      = $clog2(MAX_N_REQ);

    typedef logic [ID_W-1:0] id_t;

    function automatic bit check_param_range(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

    function automatic bit check_param_pos2exp(input int val);
        return (val > 0) && ((val & (val - 1)) == 0);
    endfunction

    // First requester with its valid set, scanning upward from ptr and
    // wrapping at n. Returns ptr when nothing is valid (the caller gates on
    // any-valid, so that value is never acted upon).
    function automatic id_t rr_pick(input logic [MAX_N_REQ-1:0] valid,
                                    input id_t                  ptr,
                                    input int                   n);
        id_t pick;
        bit  found;
        int  idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_N_REQ; k++) begin
            if (!found && (k < n)) begin
                idx = (int'(ptr) + k) % n;
                if (valid[idx[ID_W-1:0]]) begin
                    pick  = id_t'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cxu_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// cxu_arb_id_fifo
//   In-order FIFO of requester IDs for requests in flight at the shared CXU.
//   Ports:
//     clk, rst_n   clock / asynchronous active-low reset
//     push_i       push push_id_i (ignored when full)
//     push_id_i    requester ID to enqueue
//     pop_i        drop the head entry (ignored when empty)
//     head_o       oldest in-flight requester ID
//     full_o       count == DEPTH
//     empty_o      count == 0
//     count_o      current occupancy
// ---------------------------------------------------------------------------
module cxu_arb_id_fifo
    import cxu_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  id_t              push_id_i,
    input  logic             pop_i,
    output id_t              head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    id_t              mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // read behind count/pointers, which are reset, so it maps to plain flops
    // or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/cxu_arbiter.sv
// ---------------------------------------------------------------------------
// cxu_arbiter
//   Shares one downstream CXU among N_REQ requesters. Requests are granted
//   round-robin with a zero-cycle combinational path; the granted requester
//   ID is queued in an in-order FIFO and used to route each in-order CXU
//   response back to its owner.
//   Ports:
//     clk, rst_n       clock / asynchronous active-low reset
//     req_valid/ready  per-requester request handshake
//     req_data         per-requester request payloads
//     cxu_req_*        request channel to the shared CXU
//     cxu_resp_*       response channel from the shared CXU
//     resp_valid       one-hot response valid to the owning requester
//     resp_ready       per-requester response accept
//     resp_data        response payload, broadcast
//     grant_cnt        per-requester accepted-request counters
//   Optional feature macro: CXU_ARB_STATS_EN (adds grant_cnt and counters).
// ---------------------------------------------------------------------------
module cxu_arbiter
    import cxu_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int REQ_W   = 64,
    parameter int RESP_W  = 33,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][REQ_W-1:0]  req_data,
    output logic                         cxu_req_valid,
    input  logic                         cxu_req_ready,
    output logic [REQ_W-1:0]             cxu_req_data,
    input  logic                         cxu_resp_valid,
    output logic                         cxu_resp_ready,
    input  logic [RESP_W-1:0]            cxu_resp_data,
    output logic [N_REQ-1:0]             resp_valid,
    input  logic [N_REQ-1:0]             resp_ready,
    output logic [RESP_W-1:0]            resp_data
`ifdef CXU_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][31:0]       grant_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    if (!check_param_range(N_REQ, 2, MAX_N_REQ)) begin : g_bad_n_req
        $error("cxu_arbiter: N_REQ must be in [2,16]");
    end
    if (!check_param_pos2exp(MAX_OUT)) begin : g_bad_max_out
        $error("cxu_arbiter: MAX_OUT must be a positive power of two");
    end

    logic                 run_q;
    id_t                  rr_ptr_q, rr_ptr_d;
    id_t                  grant, head;
    logic [MAX_N_REQ-1:0] valid_pad;
    logic                 any_valid;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 req_hs, resp_hs;

    // Request side ---------------------------------------------------------
    always_comb begin
        valid_pad              = '0;
        valid_pad[N_REQ-1:0]   = req_valid;
        any_valid              = |req_valid;
        grant                  = rr_pick(valid_pad, rr_ptr_q, N_REQ);
    end

    // Gating uses only the registered FIFO count, so a same-cycle response
    // pop can never open the request side combinationally.
    always_comb begin
        cxu_req_valid = run_q && any_valid && !fifo_full;
        cxu_req_data  = '0;
        req_ready     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == id_t'(i)) begin
                cxu_req_data = req_data[i];
                req_ready[i] = cxu_req_valid && cxu_req_ready;
            end
        end
        req_hs = cxu_req_valid && cxu_req_ready;
    end

    // The pointer moves only on a handshake, so a held request keeps its
    // grant and every requester is reached within N_REQ handshakes.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (req_hs) begin
            rr_ptr_d = (grant == id_t'(N_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Response side --------------------------------------------------------
    always_comb begin
        resp_valid     = '0;
        cxu_resp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (head == id_t'(i)) begin
                resp_valid[i]  = cxu_resp_valid && !fifo_empty;
                cxu_resp_ready = resp_ready[i] && !fifo_empty;
            end
        end
        resp_data = cxu_resp_data;
        resp_hs   = cxu_resp_valid && cxu_resp_ready;
    end

    // run_q holds the request outputs low while reset is asserted (and for
    // the first edge after release) without routing rst_n into logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            run_q    <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    cxu_arb_id_fifo #(
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (req_hs),
        .push_id_i (grant),
        .pop_i     (resp_hs),
        .head_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

`ifdef CXU_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_hs && (grant == id_t'(i))) grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grant_cnt_q <= '0;
        else        grant_cnt_q <= grant_cnt_d;
    end

    assign grant_cnt = grant_cnt_q;
`endif

    // A response with nothing in flight means the CXU and arbiter disagree.
    a_resp_needs_inflight: assert property (
        @(posedge clk) disable iff (!rst_n) !(cxu_resp_valid && fifo_empty));

    a_count_bounded: assert property (
        @(posedge clk) disable iff (!rst_n) fifo_count <= CNT_W'(MAX_OUT));

endmodule
